// File: rtl/lsu_channel.sv
// Load/store channel for one thread: issues a single memory read or write per
// scheduler REQUEST and reports the result until the UPDATE stage.
module lsu_channel #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam int unsigned CNT_BITS = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]  REQUEST  = 3'b011;
  localparam logic [2:0]  UPDATE   = 3'b110;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    REQUESTING = 2'b01,
    WAITING    = 2'b10,
    DONE       = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic                 is_read_q, is_read_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 ready_c;
  logic                 timeout_c;

  // Only the ready of the latched operation can complete the transaction.
  assign ready_c   = is_read_q ? mem_read_ready : mem_write_ready;
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        // Read has priority when both decodes are asserted.
        if (core_state == REQUEST && (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          is_read_d = decoded_mem_read_enable;
          state_d   = REQUESTING;
        end
      end
      REQUESTING: begin
        if (is_read_q) begin
          rd_addr_d  = ADDR_BITS'(rs);
          rd_valid_d = 1'b1;
        end else begin
          wr_addr_d  = ADDR_BITS'(rs);
          wr_data_d  = rt;
          wr_valid_d = 1'b1;
        end
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = WAITING;
      end
      WAITING: begin
        if (ready_c) begin
          if (is_read_q) out_d = mem_read_data;
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
          if (timeout_c) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            err_d      = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (core_state == UPDATE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      is_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else if (enable) begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu_channel.sv
// Directed bench for lsu_channel: transaction-level model compared every cycle,
// plus literal checks on the hand-worked scenarios.
module tb_lsu_channel;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;
  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE  = 3'b110;
  localparam logic [2:0] OTHER   = 3'b000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable;
  logic [2:0]    core_state;
  logic          rd_en, wr_en;
  logic [DW-1:0] rs, rt;
  logic          mem_read_valid, mem_write_valid;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_read_data, mem_write_data;
  logic          mem_read_ready, mem_write_ready;
  logic [1:0]    lsu_state;
  logic [DW-1:0] lsu_out;
  logic          lsu_error;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  lsu_channel #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction model: phase 0 idle, 1 issuing, 2 outstanding, 3 reporting.
  int            m_phase = 0;
  bit            m_rd = 1'b0;
  int            m_wait = 0;
  bit            m_rv = 1'b0, m_wv = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_raddr = '0, m_waddr = '0;
  logic [DW-1:0] m_wdata = '0, m_out = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_rd = 1'b0; m_wait = 0; m_rv = 1'b0; m_wv = 1'b0; m_err = 1'b0;
      m_raddr = '0; m_waddr = '0; m_wdata = '0; m_out = '0;
    end else if (enable) begin
      case (m_phase)
        0: if (core_state == REQUEST && (rd_en || wr_en)) begin
             m_rd = rd_en;
             m_phase = 1;
           end
        1: begin
             if (m_rd) begin m_raddr = rs; m_rv = 1'b1; end
             else begin m_waddr = rs; m_wdata = rt; m_wv = 1'b1; end
             m_err = 1'b0; m_wait = 0; m_phase = 2;
           end
        2: if (m_rd ? mem_read_ready : mem_write_ready) begin
             if (m_rd) m_out = mem_read_data;
             m_rv = 1'b0; m_wv = 1'b0; m_phase = 3;
           end else begin
             m_wait++;
             if (TO != 0 && m_wait == TO) begin
               m_rv = 1'b0; m_wv = 1'b0; m_err = 1'b1; m_phase = 3;
             end
           end
        default: if (core_state == UPDATE) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("lsu_state", 32'(lsu_state), 32'(m_phase));
      check("mem_read_valid", 32'(mem_read_valid), 32'(m_rv));
      check("mem_write_valid", 32'(mem_write_valid), 32'(m_wv));
      check("mem_read_address", 32'(mem_read_address), 32'(m_raddr));
      check("mem_write_address", 32'(mem_write_address), 32'(m_waddr));
      check("mem_write_data", 32'(mem_write_data), 32'(m_wdata));
      check("lsu_out", 32'(lsu_out), 32'(m_out));
      check("lsu_error", 32'(lsu_error), 32'(m_err));
      check("valid_exclusive", 32'(mem_read_valid & mem_write_valid), 32'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [DW-1:0] a, input logic [DW-1:0] d);
    rs = a; rt = d; rd_en = rd; wr_en = wr; core_state = REQUEST;
    tick();
    core_state = OTHER; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    enable = 1'b1; core_state = OTHER; rd_en = 1'b0; wr_en = 1'b0; rs = '0; rt = '0;
    mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    check("rst_state", 32'(lsu_state), 32'h0);
    check("rst_rvalid", 32'(mem_read_valid), 32'h0);
    check("rst_out", 32'(lsu_out), 32'h0);
    check("rst_err", 32'(lsu_error), 32'h0);
    reset = 1'b1;
    tick();

    // load: three WAITING cycles without ready, ready coincides with timeout edge
    mem_read_data = 8'h5C;
    issue(1'b1, 1'b0, 8'h2A, 8'h00);
    check("ld_requesting", 32'(lsu_state), 32'h1);
    tick();
    check("ld_waiting", 32'(lsu_state), 32'h2);
    check("ld_addr", 32'(mem_read_address), 32'h2A);
    tick(); tick(); tick();
    check("ld_still_wait", 32'(mem_read_valid), 32'h1);
    mem_read_ready = 1'b1;
    tick();
    check("ld_done", 32'(lsu_state), 32'h3);
    check("ld_out", 32'(lsu_out), 32'h5C);
    check("ld_no_err", 32'(lsu_error), 32'h0);
    mem_read_data = 8'hEE;
    tick();
    check("done_ignores_ready", 32'(lsu_out), 32'h5C);
    mem_read_ready = 1'b0; core_state = UPDATE;
    tick();
    check("ld_idle", 32'(lsu_state), 32'h0);
    core_state = OTHER;

    // store with a stray read ready that must be ignored
    issue(1'b0, 1'b1, 8'h10, 8'hF0);
    mem_read_ready = 1'b1;
    tick();
    check("st_wvalid", 32'(mem_write_valid), 32'h1);
    check("st_waddr", 32'(mem_write_address), 32'h10);
    check("st_wdata", 32'(mem_write_data), 32'hF0);
    tick();
    mem_write_ready = 1'b1;
    tick();
    check("st_done", 32'(lsu_state), 32'h3);
    check("st_out_kept", 32'(lsu_out), 32'h5C);
    mem_write_ready = 1'b0; mem_read_ready = 1'b0; core_state = UPDATE;
    tick();
    core_state = OTHER;

    // both decodes: read wins, minimum latency
    mem_read_data = 8'h77; mem_read_ready = 1'b1;
    issue(1'b1, 1'b1, 8'h04, 8'hAB);
    tick();
    check("both_rvalid", 32'(mem_read_valid), 32'h1);
    check("both_wvalid", 32'(mem_write_valid), 32'h0);
    check("both_addr", 32'(mem_read_address), 32'h04);
    tick();
    check("both_done", 32'(lsu_state), 32'h3);
    check("both_out", 32'(lsu_out), 32'h77);
    mem_read_ready = 1'b0; core_state = UPDATE;
    tick();
    core_state = OTHER;

    // timeout after four WAITING cycles, then a fresh request clears the error
    issue(1'b1, 1'b0, 8'h33, 8'h00);
    tick(); tick(); tick(); tick();
    check("to_before", 32'(lsu_state), 32'h2);
    tick();
    check("to_done", 32'(lsu_state), 32'h3);
    check("to_rvalid", 32'(mem_read_valid), 32'h0);
    check("to_err", 32'(lsu_error), 32'h1);
    check("to_out_kept", 32'(lsu_out), 32'h77);
    core_state = UPDATE;
    tick();
    check("to_err_persist", 32'(lsu_error), 32'h1);
    core_state = OTHER;
    issue(1'b1, 1'b0, 8'h34, 8'h00);
    tick();
    check("to_err_cleared", 32'(lsu_error), 32'h0);
    mem_read_data = 8'h99; mem_read_ready = 1'b1;
    tick();
    check("to_next_out", 32'(lsu_out), 32'h99);
    mem_read_ready = 1'b0; core_state = UPDATE;
    tick();
    core_state = OTHER;

    // enable low freezes an outstanding load even with ready high
    issue(1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    enable = 1'b0; mem_read_data = 8'h12; mem_read_ready = 1'b1;
    tick(); tick();
    check("frz_state", 32'(lsu_state), 32'h2);
    check("frz_out", 32'(lsu_out), 32'h99);
    enable = 1'b1;
    tick();
    check("frz_release", 32'(lsu_out), 32'h12);
    mem_read_ready = 1'b0; core_state = UPDATE;
    tick();
    core_state = OTHER;

    // asynchronous reset while a load is outstanding
    issue(1'b1, 1'b0, 8'h55, 8'h00);
    tick();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_rvalid", 32'(mem_read_valid), 32'h0);
    check("arst_state", 32'(lsu_state), 32'h0);
    check("arst_out", 32'(lsu_out), 32'h0);
    tick();
    reset = 1'b1;
    tick(); tick();
    check("arst_stays_idle", 32'(lsu_state), 32'h0);

    // disabled thread ignores a request
    enable = 1'b0; core_state = REQUEST; rd_en = 1'b1; rs = 8'h66;
    tick(); tick();
    check("dis_state", 32'(lsu_state), 32'h0);
    check("dis_rvalid", 32'(mem_read_valid), 32'h0);
    enable = 1'b1; core_state = OTHER; rd_en = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
